dcache_wbuf: RTL
================

// Module: dcache_wbuf
// PURPOSE
//  Posted write buffer between the dcache refill/writeback port and the sram bus interconnect.
//  - Accepts dcache line writebacks and forwards them to memory in order, so dcache refills need not wait.
//  - Passes dcache line reads through. A read to a line with a pending write is held until that write drains.
//  - Reports empty for fence_d completion.
// PARAMETERS
//  DEPTH     2    write-queue entries; power of two, >=2
//  AW        32   address width
//  DW        256  line data width
//  LINE_OFF  5    line offset bits; hazard compare uses addr[AW-1:LINE_OFF]
// PORTS
//  clk        in   1    clock; all state on posedge
//  rst_n      in   1    synchronous reset, active-high despite name
//  r_req      in   1    upstream read request
//  r_type     in   6    read burst type, passed unchanged
//  r_addr     in   AW   read address
//  r_rdy      out  1    read accepted when r_req&&r_rdy
//  re_data    out  DW   read return data
//  re_valid   out  1    one-cycle read return pulse
//  w_req      in   1    upstream write request
//  w_type     in   6    write type
//  w_addr     in   AW   write address
//  w_strb     in   16   write strobes
//  w_data     in   DW   write data
//  w_rdy      out  1    write accepted when w_req&&w_rdy
//  dn_r_*     out/in    same read bus toward interconnect (req,type,addr out; rdy,data,valid in)
//  dn_w_*     out/in    same write bus toward interconnect (req,type,addr,strb,data out; rdy in)
//  wb_empty   out  1    no buffered write; fence_d waits on this
// BEHAVIOUR
//  Reset: queue empty, rd/wr ptrs=0, read FSM=R_IDLE.
//  Reset outputs: r_rdy=0, re_valid=0, dn_r_req=0, dn_w_req=0, w_rdy=1, wb_empty=1.
//  Data outputs reset to 0.
//  Reset mid-transfer drops buffered writes and the outstanding read. Any late dn_re_valid is ignored.
//  Write queue:
//  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
//  - full when MSBs differ and low bits are equal; empty when the pointers are equal.
//  - w_rdy = !full, from registers only. No bypass: an accepted write appears on dn_w_* the next cycle.
//  - dn_w_req = !empty. Head entry fields drive dn_w_*.
//  - Dequeue on dn_w_req&&dn_w_rdy. dn_w_* must stay stable until dequeued.
//  - Enqueue and dequeue in the same cycle keeps count constant. Full blocks enqueue even if a dequeue occurs.
//  - Writes leave strictly in acceptance order.
//  - wb_empty = empty (registered state).
//  Read path, FSM R_IDLE / R_WAIT:
//  - hazard = r_req and any valid entry with addr[AW-1:LINE_OFF]==r_addr[AW-1:LINE_OFF].
//  - hazard compares registered entries only. A write enqueued in the same cycle is ordered after the read.
//  - R_IDLE: dn_r_req = r_req&&!hazard; r_rdy = dn_r_rdy&&!hazard.
//    dn_r_addr and dn_r_type equal r_addr and r_type.
//    On dn_r_req&&dn_r_rdy go to R_WAIT.
//  - R_WAIT: dn_r_req=0, r_rdy=0. re_data=dn_re_data, re_valid=dn_re_valid.
//    On dn_re_valid return to R_IDLE.
//  - re_valid is forced to 0 in R_IDLE.
//  - One read outstanding at most. A hazarded read stalls: r_rdy=0 until the matching entries dequeue.
//  - A read may overtake queued writes to other lines.
//  Widths: strobes and data are stored verbatim; no merging or coalescing of writes to the same line.
// STRUCTURE
//  Package sram_bus_pkg:
//  - SRAM_AW, SRAM_DW, SRAM_TYPE_W=6, SRAM_STRB_W=16, LINE_OFF
//  - typedef sram_w_req_t {addr,type,strb,data}
//  - read FSM state enum
//  Sub-module wbuf_fifo:
//  - DEPTH-entry register FIFO of sram_w_req_t.
//  - Exports full/empty, head entry, and per-entry {valid,line_addr} vectors for the hazard compare.
//  - Top level holds the read FSM and hazard logic.
// TESTING
//  1. Reset with dn_w_rdy=0; push 0x8000_0000 and 0x8000_0040.
//     -> w_rdy drops after 2nd accept; dn_w_addr=0x8000_0000.
//     -> raise dn_w_rdy: both drain in order; wb_empty=1 the cycle after the last dequeue.
//  2. Buffer holds 0x8000_0020, dn_w_rdy=0; r_req addr 0x8000_0038 (same line).
//     -> r_rdy=0, dn_r_req=0 until that write dequeues; the read issues the next cycle.
//  3. Buffer holds 0x8000_0020; read 0x8000_1000.
//     -> dn_r_req same cycle, read issued before the write.
//     -> re_valid pulses exactly once with dn_re_data=0xA5..A5.
//  4. Full buffer, dn_w_rdy=1 and w_req same cycle.
//     -> dequeue happens, enqueue refused (w_rdy=0); accepted next cycle.
//  5. Spurious dn_re_valid in R_IDLE -> re_valid stays 0.
//     Second r_req while in R_WAIT -> r_rdy=0 until return.
//  6. Assert rst_n with 2 entries buffered and a read in R_WAIT.
//     -> next cycle wb_empty=1, dn_w_req=0, FSM R_IDLE; a later dn_re_valid is ignored.

Source files
------------

// File: rtl/sram_bus_pkg.sv
// Shared widths, write-request payload and read-FSM states for the dcache/sram bus.
package sram_bus_pkg;

  localparam int unsigned SRAM_AW       = 32;
  localparam int unsigned SRAM_DW       = 256;
  localparam int unsigned SRAM_TYPE_W   = 6;
  localparam int unsigned SRAM_STRB_W   = 16;
  localparam int unsigned SRAM_LINE_OFF = 5;

  typedef struct packed {
    logic [SRAM_AW-1:0]     addr;
    logic [SRAM_TYPE_W-1:0] wtype;
    logic [SRAM_STRB_W-1:0] strb;
    logic [SRAM_DW-1:0]     data;
  } sram_w_req_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_WAIT = 1'b1
  } rd_state_e;

endpackage

// File: rtl/dcache_wbuf_if.sv
// Line read/write bus; master issues requests, slave accepts and returns reads.
interface dcache_wbuf_if;
  import sram_bus_pkg::*;

  logic                   r_req;
  logic [SRAM_TYPE_W-1:0] r_type;
  logic [SRAM_AW-1:0]     r_addr;
  logic                   r_rdy;
  logic [SRAM_DW-1:0]     re_data;
  logic                   re_valid;
  logic                   w_req;
  logic [SRAM_TYPE_W-1:0] w_type;
  logic [SRAM_AW-1:0]     w_addr;
  logic [SRAM_STRB_W-1:0] w_strb;
  logic [SRAM_DW-1:0]     w_data;
  logic                   w_rdy;

  modport master (
    output r_req, r_type, r_addr, w_req, w_type, w_addr, w_strb, w_data,
    input  r_rdy, re_data, re_valid, w_rdy
  );

  modport slave (
    input  r_req, r_type, r_addr, w_req, w_type, w_addr, w_strb, w_data,
    output r_rdy, re_data, re_valid, w_rdy
  );

endinterface

// File: rtl/wbuf_fifo.sv
// Register FIFO of posted line writes; exposes per-entry line addresses for hazard checks.
module wbuf_fifo
  import sram_bus_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned LINE_OFF = SRAM_LINE_OFF
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      push_i,
  input  sram_w_req_t                               push_data_i,
  input  logic                                      pop_i,
  output logic                                      full_o,
  output logic                                      empty_o,
  output sram_w_req_t                               head_o,
  output logic [DEPTH-1:0]                          valid_o,
  output logic [DEPTH-1:0][SRAM_AW-LINE_OFF-1:0]    line_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count;
  sram_w_req_t   mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full_o  = (wr_ptr_q[IW] != rd_ptr_q[IW]) && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count   = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[IW-1:0]];

  // Pointer advance; full refuses a push even when a pop happens this cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Entry i is live when its distance from the head is below the occupancy.
  always_comb begin
    logic [IW-1:0] off;
    off     = '0;
    valid_o = '0;
    line_o  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off        = IW'(i) - rd_ptr_q[IW-1:0];
      valid_o[i] = PW'(off) < count;
      line_o[i]  = mem_q[i].addr[SRAM_AW-1:LINE_OFF];
    end
  end

  // Storage and pointers; reset is synchronous and active-high on rst_n.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[IW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/dcache_wbuf.sv
// Posted write buffer with hazard-checked read pass-through between dcache and sram bus.
module dcache_wbuf
  import sram_bus_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned LINE_OFF = SRAM_LINE_OFF
) (
  input  logic          clk,
  input  logic          rst_n,
  dcache_wbuf_if.slave  up,
  dcache_wbuf_if.master dn,
  output logic          wb_empty
);

  rd_state_e                               state_q;
  sram_w_req_t                             push_data;
  sram_w_req_t                             head;
  logic                                    full;
  logic                                    empty;
  logic [DEPTH-1:0]                        ent_valid;
  logic [DEPTH-1:0][SRAM_AW-LINE_OFF-1:0]  ent_line;
  logic                                    hazard;
  logic                                    rd_idle;

  assign push_data = '{addr: up.w_addr, wtype: up.w_type, strb: up.w_strb, data: up.w_data};

  wbuf_fifo #(.DEPTH(DEPTH), .LINE_OFF(LINE_OFF)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (up.w_req),
    .push_data_i (push_data),
    .pop_i       (dn.w_rdy),
    .full_o      (full),
    .empty_o     (empty),
    .head_o      (head),
    .valid_o     (ent_valid),
    .line_o      (ent_line)
  );

  // Write side: head entry drives the downstream bus until dequeued.
  assign up.w_rdy  = !full;
  assign dn.w_req  = !empty;
  assign dn.w_addr = head.addr;
  assign dn.w_type = head.wtype;
  assign dn.w_strb = head.strb;
  assign dn.w_data = head.data;
  assign wb_empty  = empty;

  // Read hazard against buffered entries only; same-cycle pushes order after the read.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_line[i] == up.r_addr[SRAM_AW-1:LINE_OFF])) hazard = 1'b1;
    end
    hazard = hazard && up.r_req;
  end

  // Read pass-through; requests are held off while in reset.
  assign rd_idle     = (state_q == R_IDLE) && !rst_n;
  assign dn.r_req    = rd_idle && up.r_req && !hazard;
  assign up.r_rdy    = rd_idle && dn.r_rdy && !hazard;
  assign dn.r_addr   = up.r_addr;
  assign dn.r_type   = up.r_type;
  assign up.re_valid = (state_q == R_WAIT) && !rst_n && dn.re_valid;
  assign up.re_data  = (state_q == R_WAIT) ? dn.re_data : '0;

  // Single-outstanding read FSM.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= R_IDLE;
    end else begin
      case (state_q)
        R_IDLE:  if (dn.r_req && dn.r_rdy) state_q <= R_WAIT;
        R_WAIT:  if (dn.re_valid)          state_q <= R_IDLE;
        default:                           state_q <= R_IDLE;
      endcase
    end
  end

endmodule
